data_sync_ctrl: RTL and testbench
=================================

# data_sync_ctrl

Destination-domain controller that sequences a multi-bit clock-domain crossing with a 4-phase REQ/ACK handshake. It synchronizes the source's REQ level, captures the quasi-static source bus only after REQ is stable, and presents the word to a local consumer with VALID/READY. It then returns ACK, which the source domain synchronizes back. It sits at every multi-bit register/config crossing in the multi-clock system, alongside the existing bus synchronizers.

## Interface
- BUS_WIDTH, 8, width of the crossing data word
- NUM_STAGES, 2, flop count of the REQ synchronizer chain (min 2)
- CLK  in  1  destination-domain clock
- RST  in  1  synchronous, active-high reset
- UNSYNC_BUS  in  BUS_WIDTH  source data; held stable by the source while REQ=1
- REQ  in  1  source request level; asynchronous to CLK
- SYNC_BUS  out  BUS_WIDTH  captured data word, registered
- SYNC_VALID  out  1  SYNC_BUS holds an undelivered word
- SYNC_READY  in  1  consumer accepts the word when SYNC_VALID=1
- ACK  out  1  handshake return to the source, registered, glitch-free
- BUSY  out  1  high whenever the FSM is not in IDLE
- PROTO_ERR  out  1  one-cycle pulse when REQ falls before delivery completes
- XFER_CNT  out  16  completed transfers, wraps 0xFFFF→0

## Operation
- REQ passes through a NUM_STAGES synchronous-reset flop chain, giving req_s. UNSYNC_BUS is never synchronized bit-wise. It is sampled only in IDLE when req_s=1.
- FSM states:
  - IDLE:
    - Outputs: ACK=0, SYNC_VALID=0.
    - If req_s=1: load SYNC_BUS←UNSYNC_BUS, set SYNC_VALID=1, go to DELIVER.
  - DELIVER:
    - Holds SYNC_BUS and SYNC_VALID=1.
    - On SYNC_VALID & SYNC_READY: clear SYNC_VALID, set ACK=1, increment XFER_CNT, go to ACKED.
  - ACKED:
    - ACK=1.
    - When req_s=0: clear ACK, go to IDLE.
- REQ falling while in DELIVER (req_s=0):
  - PROTO_ERR pulses once.
  - The word is still delivered.
  - After READY, the FSM passes through ACKED and immediately returns to IDLE because req_s is already 0.
- SYNC_BUS holds its last value in all states. It changes only at capture.
- BUSY = (state != IDLE), registered with the state.
- Reset values:
  - SYNC_BUS=0, SYNC_VALID=0, ACK=0, BUSY=0, PROTO_ERR=0, XFER_CNT=0.
  - Synchronizer chain all 0; state IDLE.
- Reset mid-transfer:
  - Everything returns to its reset value at the next edge.
  - If REQ is still high, a fresh capture occurs NUM_STAGES+1 edges after RST deasserts. Duplicate delivery in this case is the defined behaviour.

## Timing
- REQ rising, first sampled at edge 0:
  - req_s=1 after edge NUM_STAGES-1.
  - SYNC_VALID=1 and SYNC_BUS valid after edge NUM_STAGES. Latency is NUM_STAGES+1 edges, which is 3 at the default.
- SYNC_READY already high when SYNC_VALID rises: the transfer completes at the next edge, so VALID is high for exactly one cycle and ACK=1 after that edge.
- ACK rises exactly one edge after the VALID&READY edge.
- ACK falls NUM_STAGES+1 edges after REQ falls, counted from first sampling.
- Back-to-back transfers: the minimum cycle is bounded by two synchronizer traversals per phase. There is no combinational path from REQ or UNSYNC_BUS to any output.
- XFER_CNT increments on the same edge that ACK rises.

## Structure
- The shared package holds:
  - the state enum (IDLE, DELIVER, ACKED), 2-bit encoding
  - the XFER_CNT width constant (16)
  - the minimum-stages constant (2)
- One sub-module, bit_sync_sh: a 1-bit NUM_STAGES flop chain with synchronous active-high reset, used for REQ.
- The source-side ACK synchronizer lives in the source domain's block, not in this block.

## Test plan
- Reset, then REQ=1 with UNSYNC_BUS=0xA5 and READY=1:
  - SYNC_VALID=1 with SYNC_BUS=0xA5 exactly 3 edges after REQ.
  - ACK=1 one edge later; XFER_CNT=1.
- READY held low for 10 cycles:
  - SYNC_VALID and SYNC_BUS=0x3C stable for the whole interval.
  - ACK stays 0 until the READY edge.
- Four back-to-back 4-phase handshakes with data 0x01, 0x02, 0x04, 0x08:
  - All four are delivered in order; XFER_CNT=4.
  - ACK rises 4 times and never glitches.
- REQ dropped while in DELIVER:
  - PROTO_ERR pulses for exactly 1 cycle; the word is still delivered on READY.
  - ACK=1 for exactly one cycle, then the FSM returns to IDLE.
- RST asserted in ACKED with REQ still 1:
  - All outputs return to 0 at the next edge.
  - A re-capture occurs 3 edges after RST drops.
- XFER_CNT preloaded near wrap by 65535 transfers (or forced): the next transfer reads 0.

Source files
------------

// File: rtl/data_sync_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : data_sync_ctrl_pkg                                           |
// | Purpose : Shared types and constants for the REQ/ACK multi-bit CDC     |
// |           controller (state encoding, counter width, stage minimum).   |
// | Ports   : none (package)                                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package data_sync_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELIVER = 2'd1,
    ST_ACKED   = 2'd2
  } state_t;

  localparam int XFER_CNT_W = 16;
  localparam int MIN_STAGES = 2;

endpackage
`default_nettype wire

// File: rtl/data_sync_ctrl_bit_sync_sh.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : bit_sync_sh                                                  |
// | Purpose : Single-bit level synchronizer, NUM_STAGES flop shift chain   |
// |           with synchronous active-high reset.                          |
// | Ports   : clk  - destination clock                                     |
// |           rst  - synchronous active-high reset (chain clears to 0)     |
// |           d    - asynchronous level input                              |
// |           q    - synchronized level (last flop of the chain)           |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module bit_sync_sh #(
  parameter int NUM_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [NUM_STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain[0] <= d;
      for (int i = 1; i < NUM_STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign q = r_chain[NUM_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/data_sync_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : data_sync_ctrl                                               |
// | Purpose : Destination-side controller for a 4-phase REQ/ACK multi-bit  |
// |           crossing. Synchronizes REQ, captures the quasi-static source |
// |           bus once REQ is stable, hands the word to a local consumer   |
// |           with valid/ready, then returns ACK to the source.            |
// | Ports   : clk, rst            - destination clock, sync active-high rst|
// |           unsync_bus, req     - source-domain data and request level   |
// |           sync_bus, sync_valid, sync_ready - consumer handshake        |
// |           ack                 - registered handshake return            |
// |           busy                - FSM not idle                           |
// |           proto_err           - REQ withdrawn before delivery (pulse)  |
// |           xfer_cnt            - completed transfer count (wraps)       |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module data_sync_ctrl
  import data_sync_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BUS_WIDTH-1:0]  unsync_bus,
  input  logic                  req,
  output logic [BUS_WIDTH-1:0]  sync_bus,
  output logic                  sync_valid,
  input  logic                  sync_ready,
  output logic                  ack,
  output logic                  busy,
  output logic                  proto_err,
  output logic [XFER_CNT_W-1:0] xfer_cnt
);

  // A single-flop synchronizer is not metastability safe; clamp upward.
  localparam int SYNC_STAGES = (NUM_STAGES < MIN_STAGES) ? MIN_STAGES : NUM_STAGES;

  logic w_req_s;

  bit_sync_sh #(
    .NUM_STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (req),
    .q   (w_req_s)
  );

  state_t                r_state;
  state_t                w_state_nx;
  logic [BUS_WIDTH-1:0]  w_bus_nx;
  logic                  w_valid_nx;
  logic                  w_ack_nx;
  logic                  w_perr_nx;
  logic [XFER_CNT_W-1:0] w_cnt_nx;
  // Remembers that the current word already flagged an early REQ drop,
  // so the error pulses only once per transfer.
  logic                  r_err_seen;
  logic                  w_err_seen_nx;

  always_comb begin
    w_state_nx    = r_state;
    w_bus_nx      = sync_bus;
    w_valid_nx    = sync_valid;
    w_ack_nx      = ack;
    w_perr_nx     = 1'b0;
    w_cnt_nx      = xfer_cnt;
    w_err_seen_nx = r_err_seen;

    case (r_state)
      ST_IDLE: begin
        w_ack_nx   = 1'b0;
        w_valid_nx = 1'b0;
        // The source holds the bus stable while REQ is high, so once the
        // synchronized REQ is seen the whole word can be sampled at once.
        if (w_req_s) begin
          w_bus_nx      = unsync_bus;
          w_valid_nx    = 1'b1;
          w_err_seen_nx = 1'b0;
          w_state_nx    = ST_DELIVER;
        end
      end

      ST_DELIVER: begin
        if (!w_req_s && !r_err_seen) begin
          w_perr_nx     = 1'b1;
          w_err_seen_nx = 1'b1;
        end
        // The word is delivered even after an early REQ drop; ACKED then
        // falls straight through to IDLE because req_s is already low.
        if (sync_valid && sync_ready) begin
          w_valid_nx = 1'b0;
          w_ack_nx   = 1'b1;
          w_cnt_nx   = xfer_cnt + 1'b1;
          w_state_nx = ST_ACKED;
        end
      end

      ST_ACKED: begin
        w_ack_nx = 1'b1;
        if (!w_req_s) begin
          w_ack_nx   = 1'b0;
          w_state_nx = ST_IDLE;
        end
      end

      default: begin
        w_ack_nx   = 1'b0;
        w_valid_nx = 1'b0;
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // All outputs come straight from flops: no combinational path from the
  // source domain reaches a port, and ACK cannot glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      sync_bus   <= '0;
      sync_valid <= 1'b0;
      ack        <= 1'b0;
      busy       <= 1'b0;
      proto_err  <= 1'b0;
      xfer_cnt   <= '0;
      r_err_seen <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      sync_bus   <= w_bus_nx;
      sync_valid <= w_valid_nx;
      ack        <= w_ack_nx;
      busy       <= (w_state_nx != ST_IDLE);
      proto_err  <= w_perr_nx;
      xfer_cnt   <= w_cnt_nx;
      r_err_seen <= w_err_seen_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_sync_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_data_sync_ctrl                                            |
// | Purpose : Scoreboard bench for data_sync_ctrl. Stimulus pushes the     |
// |           expected word; a negedge monitor pops on each valid&ready.   |
// | Ports   : none                                                         |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_data_sync_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  unsync_bus;
  logic        req;
  logic [7:0]  sync_bus;
  logic        sync_valid;
  logic        sync_ready;
  logic        ack;
  logic        busy;
  logic        proto_err;
  logic [15:0] xfer_cnt;

  data_sync_ctrl #(
    .BUS_WIDTH  (8),
    .NUM_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .unsync_bus (unsync_bus),
    .req        (req),
    .sync_bus   (sync_bus),
    .sync_valid (sync_valid),
    .sync_ready (sync_ready),
    .ack        (ack),
    .busy       (busy),
    .proto_err  (proto_err),
    .xfer_cnt   (xfer_cnt)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_word;
  int         ack_rises = 0;
  int         perr_cycles = 0;
  logic       ack_d = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input int budget, input string name);
    int n = 0;
    while (ack !== lvl && n < budget) begin
      tick();
      n++;
    end
    chk(name, {31'd0, ack}, {31'd0, lvl});
  endtask

  // Monitor: pop expected word whenever the consumer takes one.
  always @(negedge clk) begin
    if (sync_valid && sync_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty actual=%0h required=none", sync_bus);
      end else begin
        exp_word = exp_q.pop_front();
        chk("scoreboard_word", {24'd0, sync_bus}, {24'd0, exp_word});
      end
    end
    if (ack && !ack_d) ack_rises++;
    ack_d = ack;
    if (proto_err) perr_cycles++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    req        = 1'b0;
    sync_ready = 1'b0;
    unsync_bus = 8'h00;
    tick(); tick(); tick();

    // Reset state
    chk("rst_bus",   {24'd0, sync_bus}, 32'h0);
    chk("rst_valid", {31'd0, sync_valid}, 32'h0);
    chk("rst_ack",   {31'd0, ack}, 32'h0);
    chk("rst_busy",  {31'd0, busy}, 32'h0);
    chk("rst_perr",  {31'd0, proto_err}, 32'h0);
    chk("rst_cnt",   {16'd0, xfer_cnt}, 32'h0);
    rst = 1'b0;
    tick();

    // Basic latency with READY already high
    unsync_bus = 8'hA5;
    sync_ready = 1'b1;
    exp_q.push_back(8'hA5);
    req = 1'b1;
    tick(); chk("lat_e0_valid", {31'd0, sync_valid}, 32'h0);
    tick(); chk("lat_e1_valid", {31'd0, sync_valid}, 32'h0);
    tick();
    chk("lat_e2_valid", {31'd0, sync_valid}, 32'h1);
    chk("lat_e2_bus",   {24'd0, sync_bus}, 32'hA5);
    chk("lat_e2_busy",  {31'd0, busy}, 32'h1);
    chk("lat_e2_ack",   {31'd0, ack}, 32'h0);
    tick();
    chk("lat_e3_valid", {31'd0, sync_valid}, 32'h0);
    chk("lat_e3_ack",   {31'd0, ack}, 32'h1);
    chk("lat_e3_cnt",   {16'd0, xfer_cnt}, 32'h1);
    req = 1'b0;
    tick(); chk("ackfall_e0", {31'd0, ack}, 32'h1);
    tick(); chk("ackfall_e1", {31'd0, ack}, 32'h1);
    tick();
    chk("ackfall_e2", {31'd0, ack}, 32'h0);
    chk("ackfall_busy", {31'd0, busy}, 32'h0);

    // READY held low for 10 cycles; source bus changes must not leak through
    sync_ready = 1'b0;
    unsync_bus = 8'h3C;
    exp_q.push_back(8'h3C);
    req = 1'b1;
    tick(); tick(); tick();
    unsync_bus = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", {31'd0, sync_valid}, 32'h1);
      chk("hold_bus",   {24'd0, sync_bus}, 32'h3C);
      chk("hold_ack",   {31'd0, ack}, 32'h0);
      tick();
    end
    sync_ready = 1'b1;
    tick();
    chk("hold_rel_ack",   {31'd0, ack}, 32'h1);
    chk("hold_rel_valid", {31'd0, sync_valid}, 32'h0);
    chk("hold_rel_cnt",   {16'd0, xfer_cnt}, 32'h2);
    req = 1'b0;
    wait_ack(1'b0, 10, "hold_ack_lo");

    // Four back-to-back handshakes from a clean reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    ack_rises = 0;
    for (int k = 0; k < 4; k++) begin
      unsync_bus = 8'(1 << k);
      exp_q.push_back(8'(1 << k));
      req = 1'b1;
      wait_ack(1'b1, 20, "b2b_ack_hi");
      req = 1'b0;
      wait_ack(1'b0, 20, "b2b_ack_lo");
    end
    tick();
    chk("b2b_cnt",   {16'd0, xfer_cnt}, 32'h4);
    chk("b2b_rises", ack_rises, 4);
    chk("b2b_drain", exp_q.size(), 0);

    // REQ withdrawn while the word is pending
    sync_ready = 1'b0;
    unsync_bus = 8'h5A;
    exp_q.push_back(8'h5A);
    req = 1'b1;
    tick(); tick(); tick();
    chk("perr_valid_pre", {31'd0, sync_valid}, 32'h1);
    perr_cycles = 0;
    req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("perr_cycles", perr_cycles, 1);
    chk("perr_valid_held", {31'd0, sync_valid}, 32'h1);
    chk("perr_busy", {31'd0, busy}, 32'h1);
    sync_ready = 1'b1;
    tick();
    chk("perr_ack_hi", {31'd0, ack}, 32'h1);
    chk("perr_valid_lo", {31'd0, sync_valid}, 32'h0);
    tick();
    chk("perr_ack_lo", {31'd0, ack}, 32'h0);
    chk("perr_idle", {31'd0, busy}, 32'h0);
    chk("perr_cnt", {16'd0, xfer_cnt}, 32'h5);

    // Reset while in ACKED with REQ still high: duplicate delivery expected
    unsync_bus = 8'h77;
    exp_q.push_back(8'h77);
    req = 1'b1;
    wait_ack(1'b1, 20, "rstmid_ack_hi");
    exp_q.push_back(8'h77);
    rst = 1'b1;
    tick();
    chk("rstmid_bus",   {24'd0, sync_bus}, 32'h0);
    chk("rstmid_valid", {31'd0, sync_valid}, 32'h0);
    chk("rstmid_ack",   {31'd0, ack}, 32'h0);
    chk("rstmid_busy",  {31'd0, busy}, 32'h0);
    chk("rstmid_perr",  {31'd0, proto_err}, 32'h0);
    chk("rstmid_cnt",   {16'd0, xfer_cnt}, 32'h0);
    rst = 1'b0;
    tick(); chk("recap_e0_valid", {31'd0, sync_valid}, 32'h0);
    tick(); chk("recap_e1_valid", {31'd0, sync_valid}, 32'h0);
    tick();
    chk("recap_e2_valid", {31'd0, sync_valid}, 32'h1);
    chk("recap_e2_bus",   {24'd0, sync_bus}, 32'h77);
    tick();
    chk("recap_ack", {31'd0, ack}, 32'h1);
    chk("recap_cnt", {16'd0, xfer_cnt}, 32'h1);
    req = 1'b0;
    wait_ack(1'b0, 10, "recap_ack_lo");

    // Counter wrap: preload 0xFFFF, next transfer must read 0
    force dut.xfer_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.xfer_cnt;
    #1;
    chk("wrap_pre", {16'd0, xfer_cnt}, 32'hFFFF);
    unsync_bus = 8'hC3;
    exp_q.push_back(8'hC3);
    req = 1'b1;
    wait_ack(1'b1, 20, "wrap_ack_hi");
    chk("wrap_cnt", {16'd0, xfer_cnt}, 32'h0);
    req = 1'b0;
    wait_ack(1'b0, 10, "wrap_ack_lo");
    tick();
    chk("final_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
